csi2_packet_tx: RTL and testbench
=================================

# csi2_packet_tx

Two-lane MIPI CSI-2 packet transmitter at byte level: the transmit-side counterpart of our CSI-2 receiver chain. Accepts a packet request (data type, virtual channel, word count) and a 16-bit payload stream, and emits per-lane HS bytes in order: sync, ECC-protected header, payload, CRC-16 and trail. Sits between the pixel source and the lane serializers / LP-HS pad driver, which takes `hs_req` to sequence LP-11 → LP-01 → LP-00 → HS.

## Interface
- `T_PREP`, 8: cycles `hs_req` is high before the sync byte (LP-00/HS-zero window for the pad driver).
- `T_TRAIL`, 4: number of trail bytes per lane.
- `mipi_clk`  in  1  byte clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  packet request; sampled only while `busy`=0.
- `data_type`  in  6  CSI-2 DT; values 0x00–0x0F are short packets.
- `vc`  in  2  virtual channel.
- `wordcount`  in  16  long packet: payload byte count. Short packet: 16-bit data field.
- `pix_data`  in  16  payload; [7:0] is the earlier byte (lane0), [15:8] is the later byte (lane1).
- `pix_valid`  in  1  payload word available.
- `pix_ready`  out  1  payload word consumed this cycle.
- `busy`  out  1  high from accepted `start` until the end of `done`.
- `done`  out  1  one-cycle pulse in the last TRAIL cycle.
- `err_odd`  out  1  one-cycle pulse: request rejected.
- `underrun`  out  1  one-cycle pulse: payload word missing.
- `hs_req`  out  1  HS request to the pad driver.
- `hs_valid`  out  1  lane bytes valid.
- `lane0_byte`, `lane1_byte`  out  8 each  HS bytes; the serializer shifts them out LSB first.

All outputs reset to 0.

## Operation
- FSM states: IDLE, PREP, SYNC, HEADER, PAYLOAD, CRC, TRAIL.
- IDLE:
  - On `start`, latch `data_type`, `vc` and `wordcount`.
  - Long packet with `wordcount[0]`=1: pulse `err_odd`, stay in IDLE, `busy` stays 0.
  - Otherwise go to PREP and set `busy`=1.
- PREP: `hs_req`=1, `hs_valid`=0, lasting T_PREP cycles.
- SYNC: one cycle with both lanes = 0xB8 and `hs_valid`=1. `hs_req` and `hs_valid` then stay 1 through TRAIL.
- HEADER: 2 cycles carrying header bytes B0..B3, distributed alternately.
  - Header bytes: B0 = {vc, data_type}, B1 = wc[7:0], B2 = wc[15:8], B3 = ECC.
  - Cycle 1: lane0 = B0, lane1 = B1. Cycle 2: lane0 = B2, lane1 = B3.
  - After HEADER: short packet (or long packet with wc=0) goes to TRAIL; long packet with wc=0 first passes through CRC with CRC = 0xFFFF. Other long packets go to PAYLOAD.
- ECC over the 24 bits D[23:0] = {B2, B1, B0}; ECC[7:6] = 0.
  - P0 = D0^D1^D2^D4^D5^D7^D10^D11^D13^D16^D20^D21^D22^D23
  - P1 = D0^D1^D3^D4^D6^D8^D10^D12^D14^D17^D20^D21^D22^D23
  - P2 = D0^D2^D3^D5^D6^D9^D11^D12^D15^D18^D20^D21^D22
  - P3 = D1^D2^D3^D7^D8^D9^D13^D14^D15^D19^D20^D21^D23
  - P4 = D4..D9^D16..D19^D20^D22^D23
  - P5 = D10..D19^D21^D22^D23
- PAYLOAD: lasts wc/2 cycles, with `pix_ready`=1 every cycle.
  - Each cycle: lane0 = pix_data[7:0], lane1 = pix_data[15:8].
  - If `pix_valid`=0 in a cycle: send 0x00 on both lanes, pulse `underrun`, and count the cycle anyway. HS never stalls.
- CRC:
  - CRC-16, polynomial x^16+x^12+x^5+1, reflected (0x8408), seed 0xFFFF.
  - Bytes enter in transmitted order, LSB first; two bytes per cycle (lane0 byte, then lane1 byte).
  - One cycle: lane0 = CRC[7:0], lane1 = CRC[15:8].
- TRAIL: T_TRAIL cycles. Each lane repeats 0xFF if bit 7 of its last byte was 0, else 0x00.
- After TRAIL: `hs_req`, `hs_valid` and `busy` fall on the next cycle, and the FSM returns to IDLE.
- Lane outputs are 0x00 whenever `hs_valid`=0.
- The internal byte counter is 16 bits; wc = 0xFFFE is legal and must not wrap early.

## Timing
- `start` accepted in cycle N:
  - `hs_req` and `busy` rise at N+1.
  - SYNC at N+1+T_PREP.
  - First header cycle at N+2+T_PREP.
  - First `pix_ready` at N+4+T_PREP.
- Total packet length after sync:
  - Long packet: 1 + 2 + wc/2 + 1 + T_TRAIL HS cycles.
  - Short packet: 1 + 2 + T_TRAIL HS cycles.
- `pix_ready` is a registered output and is never asserted outside PAYLOAD.
- `start` while `busy`=1 is ignored.
- `reset` in any state: next cycle, all outputs are 0 and the FSM is in IDLE. A partial packet is abandoned without TRAIL.

## Test plan
- **Short FS:** dt=0x00, vc=0, wc=0x0001.
  - lane0: B8, 00, 00. lane1: B8, 01, 1A.
  - Then 4 trail bytes: lane0 = FF, lane1 = FF.
  - `done` pulses once; no `pix_ready`.
- **Long packet, CRC vector:** dt=0x2A, wc=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01.
  - Header: lane0 = 2A, 00; lane1 = 18, 13.
  - 12 PAYLOAD cycles, then CRC: lane0 = F0, lane1 = 00.
  - Trail: lane0 = 00, lane1 = FF.
- **Odd word count:** `start` with dt=0x2A, wc=0x0281.
  - `err_odd` pulses once; `busy`, `hs_req` and `hs_valid` stay 0.
- **Underrun:** same as the CRC vector test, but `pix_valid`=0 in payload cycle 5.
  - Lanes send 00/00 in that cycle and `underrun` pulses once.
  - Packet length is unchanged; CRC matches a golden model fed with zeros.
- **Reset mid-payload:** assert `reset` in PAYLOAD cycle 3.
  - Next cycle: all outputs are 0.
  - A following `start` produces a complete, correct packet.
- **Back-to-back:** `start` held high continuously.
  - Second packet's PREP begins the cycle after `busy` falls.
  - A `start` raised while `busy`=1 does not corrupt the first packet.

Source files
------------

// File: rtl/csi2_packet_tx.sv
// rtl/csi2_packet_tx.sv - two-lane MIPI CSI-2 byte-level packet transmitter
//
// Builds one CSI-2 packet per request and spreads it over two HS lanes:
// sync, ECC-protected header, payload, CRC-16 and trail bytes.
//
// Parameters:
//   T_PREP     cycles hs_req is high before the sync byte
//   T_TRAIL    trail bytes per lane
// Ports:
//   mipi_clk, reset            byte clock, synchronous active-high reset
//   start, data_type, vc,      packet request (sampled only while idle)
//   wordcount
//   pix_data, pix_valid,       16-bit payload stream, [7:0] goes to lane0
//   pix_ready
//   busy, done, err_odd,       status pulses / levels
//   underrun
//   hs_req, hs_valid           pad-driver HS request, lane bytes valid
//   lane0_byte, lane1_byte     per-lane HS bytes
module csi2_packet_tx #(
  parameter int T_PREP  = 8,
  parameter int T_TRAIL = 4
) (
  input  logic        mipi_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  data_type,
  input  logic [1:0]  vc,
  input  logic [15:0] wordcount,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        busy,
  output logic        done,
  output logic        err_odd,
  output logic        underrun,
  output logic        hs_req,
  output logic        hs_valid,
  output logic [7:0]  lane0_byte,
  output logic [7:0]  lane1_byte
);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    SYNC,
    HEADER,
    PAYLOAD,
    CRC,
    TRAIL
  } state_t;

  localparam logic [15:0] PREP_LOAD  = 16'(T_PREP - 1);
  localparam logic [15:0] TRAIL_LOAD = 16'(T_TRAIL - 1);
  localparam logic [7:0]  SYNC_BYTE  = 8'hB8;

  state_t      state;
  logic [5:0]  dt_q;
  logic [1:0]  vc_q;
  logic [15:0] wc_q;
  logic [15:0] cnt;
  logic        hdr_phase;
  logic [15:0] crc_q;
  logic [7:0]  lane0_q;
  logic [7:0]  lane1_q;

  // Header ECC (6 parity bits, top two bits zero) over {B2, B1, B0}.
  function automatic logic [7:0] header_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]
         ^ d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]
         ^ d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]
         ^ d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]
         ^ d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]
         ^ d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]
         ^ d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  // Reflected CRC-16 (0x8408), one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Trail byte is the complement of the last bit sent on that lane.
  function automatic logic [7:0] trail_of(input logic [7:0] last);
    return last[7] ? 8'h00 : 8'hFF;
  endfunction

  logic        long_req;
  logic        long_q;
  logic [7:0]  hdr_b0;
  logic [7:0]  hdr_b1;
  logic [7:0]  hdr_b2;
  logic [7:0]  hdr_ecc;
  logic [7:0]  pay0;
  logic [7:0]  pay1;
  logic [15:0] crc_next;

  assign long_req = (data_type[5:4] != 2'b00);
  assign long_q   = (dt_q[5:4] != 2'b00);
  assign hdr_b0   = {vc_q, dt_q};
  assign hdr_b1   = wc_q[7:0];
  assign hdr_b2   = wc_q[15:8];
  assign hdr_ecc  = header_ecc({hdr_b2, hdr_b1, hdr_b0});

  // A missing payload word is replaced by zeros on the wire and in the CRC.
  assign pay0     = pix_valid ? pix_data[7:0]  : 8'h00;
  assign pay1     = pix_valid ? pix_data[15:8] : 8'h00;
  assign crc_next = crc16_byte(crc16_byte(crc_q, pay0), pay1);

  // Payload bytes go straight through in the cycle pix_ready is high, since
  // HS cannot stall; every other lane byte comes from the registers.
  assign lane0_byte = !hs_valid ? 8'h00 : (pix_ready ? pay0 : lane0_q);
  assign lane1_byte = !hs_valid ? 8'h00 : (pix_ready ? pay1 : lane1_q);
  assign underrun   = pix_ready & ~pix_valid;

  always_ff @(posedge mipi_clk) begin
    if (reset) begin
      state     <= IDLE;
      dt_q      <= '0;
      vc_q      <= '0;
      wc_q      <= '0;
      cnt       <= '0;
      hdr_phase <= 1'b0;
      crc_q     <= '0;
      lane0_q   <= '0;
      lane1_q   <= '0;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_odd   <= 1'b0;
      hs_req    <= 1'b0;
      hs_valid  <= 1'b0;
    end else begin
      err_odd <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dt_q <= data_type;
            vc_q <= vc;
            wc_q <= wordcount;
            if (long_req && wordcount[0]) begin
              err_odd <= 1'b1;
            end else begin
              state  <= PREP;
              busy   <= 1'b1;
              hs_req <= 1'b1;
              cnt    <= PREP_LOAD;
            end
          end
        end

        PREP: begin
          if (cnt == 16'd0) begin
            state    <= SYNC;
            hs_valid <= 1'b1;
            lane0_q  <= SYNC_BYTE;
            lane1_q  <= SYNC_BYTE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        SYNC: begin
          state     <= HEADER;
          hdr_phase <= 1'b0;
          lane0_q   <= hdr_b0;
          lane1_q   <= hdr_b1;
        end

        HEADER: begin
          if (!hdr_phase) begin
            hdr_phase <= 1'b1;
            lane0_q   <= hdr_b2;
            lane1_q   <= hdr_ecc;
          end else if (long_q && (wc_q != 16'd0)) begin
            state     <= PAYLOAD;
            pix_ready <= 1'b1;
            cnt       <= {1'b0, wc_q[15:1]} - 16'd1;
            crc_q     <= 16'hFFFF;
            lane0_q   <= 8'h00;
            lane1_q   <= 8'h00;
          end else if (long_q) begin
            // Empty long packet: CRC of nothing is the seed.
            state   <= CRC;
            lane0_q <= 8'hFF;
            lane1_q <= 8'hFF;
          end else begin
            state   <= TRAIL;
            lane0_q <= trail_of(lane0_q);
            lane1_q <= trail_of(lane1_q);
            cnt     <= TRAIL_LOAD;
            done    <= (T_TRAIL == 1);
          end
        end

        PAYLOAD: begin
          crc_q <= crc_next;
          if (cnt == 16'd0) begin
            state     <= CRC;
            pix_ready <= 1'b0;
            lane0_q   <= crc_next[7:0];
            lane1_q   <= crc_next[15:8];
          end else begin
            cnt <= cnt - 16'd1;
          end
        end

        CRC: begin
          state   <= TRAIL;
          lane0_q <= trail_of(lane0_q);
          lane1_q <= trail_of(lane1_q);
          cnt     <= TRAIL_LOAD;
          done    <= (T_TRAIL == 1);
        end

        TRAIL: begin
          if (cnt == 16'd0) begin
            state    <= IDLE;
            busy     <= 1'b0;
            hs_req   <= 1'b0;
            hs_valid <= 1'b0;
            lane0_q  <= 8'h00;
            lane1_q  <= 8'h00;
          end else begin
            cnt  <= cnt - 16'd1;
            done <= (cnt == 16'd1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi2_packet_tx.sv
// tb/tb_csi2_packet_tx.sv - self-checking bench for csi2_packet_tx
module tb_csi2_packet_tx;

  localparam int T_PREP  = 8;
  localparam int T_TRAIL = 4;

  logic        mipi_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  data_type;
  logic [1:0]  vc;
  logic [15:0] wordcount;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        busy;
  logic        done;
  logic        err_odd;
  logic        underrun;
  logic        hs_req;
  logic        hs_valid;
  logic [7:0]  lane0_byte;
  logic [7:0]  lane1_byte;

  csi2_packet_tx #(.T_PREP(T_PREP), .T_TRAIL(T_TRAIL)) dut (
    .mipi_clk(mipi_clk), .reset(reset), .start(start), .data_type(data_type),
    .vc(vc), .wordcount(wordcount), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .done(done), .err_odd(err_odd),
    .underrun(underrun), .hs_req(hs_req), .hs_valid(hs_valid),
    .lane0_byte(lane0_byte), .lane1_byte(lane1_byte)
  );

  always #5 mipi_clk = ~mipi_clk;

  typedef struct {
    logic [7:0] l0;
    logic [7:0] l1;
    logic       pr;
    logic       un;
    logic       dn;
  } beat_t;

  typedef struct {
    string       name;
    logic [5:0]  dt;
    logic [1:0]  vc;
    logic [15:0] wc;
    int          kind;   // payload: 0 none, 1 CRC reference vector, 2 random
    int          gap;    // payload cycle index with pix_valid=0, -1 none
    bit          err;    // request must be rejected
    int          ecc;    // literal expected ECC, -1 = use model
    int          crc;    // literal expected CRC, -1 = use model
  } vec_t;

  beat_t      exp_q[$];
  vec_t       vecs[8];
  logic [7:0] pay[0:63];
  logic [7:0] crcvec[24];
  int         pidx;
  int         gap_idx;
  int         prep_run;
  int         n_cmp;
  int         n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ecc_model(input logic [23:0] d);
    return {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
            ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  task automatic push(input logic [7:0] l0, input logic [7:0] l1,
                      input logic pr, input logic un, input logic dn);
    beat_t b;
    b.l0 = l0; b.l1 = l1; b.pr = pr; b.un = un; b.dn = dn;
    exp_q.push_back(b);
  endtask

  // Expected HS beats of one packet, pushed when the request is driven.
  task automatic build_pkt(input vec_t t);
    logic [7:0]  b0, b1, b2, b3, p0, p1, last0, last1;
    logic [15:0] crc;
    b0 = {t.vc, t.dt};
    b1 = t.wc[7:0];
    b2 = t.wc[15:8];
    b3 = (t.ecc >= 0) ? t.ecc[7:0] : ecc_model({b2, b1, b0});
    push(8'hB8, 8'hB8, 0, 0, 0);
    push(b0, b1, 0, 0, 0);
    push(b2, b3, 0, 0, 0);
    last0 = b2;
    last1 = b3;
    if (t.dt >= 6'h10) begin
      crc = 16'hFFFF;
      for (int i = 0; i < int'(t.wc) / 2; i++) begin
        p0 = (i == t.gap) ? 8'h00 : pay[2*i];
        p1 = (i == t.gap) ? 8'h00 : pay[2*i+1];
        push(p0, p1, 1, (i == t.gap), 0);
        crc = crc_model(crc_model(crc, p0), p1);
      end
      if (t.crc >= 0) crc = t.crc[15:0];
      push(crc[7:0], crc[15:8], 0, 0, 0);
      last0 = crc[7:0];
      last1 = crc[15:8];
    end
    for (int k = 0; k < T_TRAIL; k++)
      push(last0[7] ? 8'h00 : 8'hFF, last1[7] ? 8'h00 : 8'hFF, 0, 0, (k == T_TRAIL - 1));
  endtask

  // Monitor: every HS cycle is popped from the scoreboard and compared.
  always @(negedge mipi_clk) begin
    if (!reset) begin
      if (hs_valid) begin
        if (prep_run != 0) begin
          check("prep_length", prep_run, T_PREP);
          prep_run = 0;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_hs_beat", 1, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("lanes", {lane0_byte, lane1_byte}, {e.l0, e.l1});
          check("ready_underrun_done", {pix_ready, underrun, done, hs_req}, {e.pr, e.un, e.dn, 1'b1});
        end
      end else begin
        prep_run = hs_req ? prep_run + 1 : 0;
        if (pix_ready || underrun || done || (lane0_byte != 0) || (lane1_byte != 0))
          check("quiet_outside_hs", {pix_ready, underrun, done, lane0_byte, lane1_byte}, 0);
      end
    end
  end

  // Payload source: presents the next word whenever the DUT asks for one.
  always @(posedge mipi_clk) begin
    #1;
    if (pix_ready) begin
      pix_valid = (pidx != gap_idx);
      pix_data  = (pix_valid && pidx < 32) ? {pay[2*pidx+1], pay[2*pidx]} : 16'hA5C3;
      pidx++;
    end else begin
      pix_valid = 1'b0;
      pix_data  = 16'hDEAD;
    end
  end

  task automatic load_payload(input int kind);
    for (int i = 0; i < 64; i++)
      pay[i] = (kind == 1 && i < 24) ? crcvec[i] : 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 3000) begin
      @(posedge mipi_clk); #1;
      k++;
    end
    if (k >= 3000) check({name, "_done_timeout"}, 0, 1);
    @(posedge mipi_clk); #1;
    check({name, "_end_idle"}, {busy, hs_req, hs_valid, pix_ready}, 4'b0000);
    check({name, "_scoreboard_drained"}, exp_q.size(), 0);
  endtask

  task automatic run_vec(input vec_t t);
    load_payload(t.kind);
    gap_idx = t.gap;
    pidx    = 0;
    if (!t.err) build_pkt(t);
    @(posedge mipi_clk); #1;
    data_type = t.dt; vc = t.vc; wordcount = t.wc; start = 1'b1;
    @(posedge mipi_clk); #1;
    start = 1'b0;
    if (t.err) begin
      check({t.name, "_err_odd"}, {err_odd, busy, hs_req, hs_valid}, 4'b1000);
      @(posedge mipi_clk); #1;
      check({t.name, "_err_pulse_end"}, {err_odd, busy, hs_req, hs_valid}, 4'b0000);
    end else begin
      check({t.name, "_busy_rise"}, {busy, hs_req, hs_valid}, 3'b110);
      wait_done(t.name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int c;
    n_cmp = 0; n_bad = 0; prep_run = 0; pidx = 0; gap_idx = -1;
    reset = 1'b1; start = 1'b0; data_type = '0; vc = '0; wordcount = '0;
    pix_data = '0; pix_valid = 1'b0;
    crcvec = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
               8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
               8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

    //          name          dt     vc    wc         kind gap err ecc    crc
    vecs[0] = '{"short_fs",   6'h00, 2'd0, 16'h0001, 0, -1, 0, 'h1A, -1};
    vecs[1] = '{"crc_vector", 6'h2A, 2'd0, 16'd24,   1, -1, 0, 'h13, 'h00F0};
    vecs[2] = '{"odd_wc",     6'h2A, 2'd0, 16'h0281, 0, -1, 1, -1,   -1};
    vecs[3] = '{"underrun",   6'h2A, 2'd0, 16'd24,   1,  4, 0, 'h13, -1};
    vecs[4] = '{"long_wc0",   6'h2B, 2'd1, 16'h0000, 0, -1, 0, -1,   'hFFFF};
    vecs[5] = '{"long_rand",  6'h1E, 2'd3, 16'd40,   2, -1, 0, -1,   -1};
    vecs[6] = '{"short_data", 6'h03, 2'd2, 16'hABCD, 0, -1, 0, -1,   -1};
    vecs[7] = '{"long_wc2",   6'h24, 2'd1, 16'd2,    2, -1, 0, -1,   -1};

    repeat (3) @(posedge mipi_clk);
    #1;
    check("reset_outputs", {pix_ready, busy, done, err_odd, underrun, hs_req, hs_valid,
                            lane0_byte, lane1_byte}, 0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) run_vec(vecs[v]);

    // Reset during payload cycle 3 abandons the packet immediately.
    load_payload(1);
    gap_idx = -1;
    pidx    = 0;
    build_pkt(vecs[1]);
    @(posedge mipi_clk); #1;
    data_type = 6'h2A; vc = 2'd0; wordcount = 16'd24; start = 1'b1;
    @(posedge mipi_clk); #1;
    start = 1'b0;
    c = 0;
    for (int k = 0; k < 100 && c < 3; k++) begin
      if (pix_ready) c++;
      if (c < 3) begin
        @(posedge mipi_clk); #1;
      end
    end
    check("reset_reached_payload3", c, 3);
    reset = 1'b1;
    @(posedge mipi_clk); #1;
    check("reset_mid_payload_outputs", {pix_ready, busy, done, err_odd, underrun, hs_req,
                                        hs_valid, lane0_byte, lane1_byte}, 0);
    exp_q.delete();
    prep_run = 0;
    reset = 1'b0;
    run_vec(vecs[1]);

    // Back-to-back: start held high; inputs change while busy.
    load_payload(1);
    gap_idx = -1;
    pidx    = 0;
    build_pkt(vecs[1]);
    build_pkt(vecs[0]);
    @(posedge mipi_clk); #1;
    data_type = 6'h2A; vc = 2'd0; wordcount = 16'd24; start = 1'b1;
    @(posedge mipi_clk); #1;
    check("b2b_first_busy", {busy, hs_req}, 2'b11);
    data_type = 6'h00; vc = 2'd0; wordcount = 16'h0001;
    c = 0;
    while (busy && c < 3000) begin
      @(posedge mipi_clk); #1;
      c++;
    end
    check("b2b_busy_fell", busy, 0);
    @(posedge mipi_clk); #1;
    check("b2b_restart_next_cycle", {busy, hs_req, hs_valid}, 3'b110);
    start = 1'b0;
    wait_done("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
